// File: rtl/snoop_bus_ctrl_pkg.sv
// Shared types for the two-CPU MSI snooping bus controller.
// Block states, bus operations, controller FSM states and the block address width.
package snoop_bus_ctrl_pkg;

   typedef enum logic [1:0] {
      INVALID  = 2'b00,
      SHARED   = 2'b01,
      MODIFIED = 2'b10
   } blk_state_t;

   typedef enum logic [1:0] {
      OP_RD,
      OP_WR,
      OP_INV
   } bus_op_t;

   typedef enum logic [1:0] {
      SB_IDLE,
      SB_SNOOP,
      SB_RESP,
      SB_GRANT
   } sb_state_t;

   localparam int BLK_ADDR_W = 11;

   function automatic logic [1:0] cpu_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/snoop_bus_ctrl_rr_arbiter2.sv
// Two-request round-robin picker with its own favoured-CPU pointer.
// A lone requester always wins; on a tie the pointer decides.
module rr_arbiter2
   import snoop_bus_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       update,
   input  logic       next_ptr,
   output logic       valid,
   output logic       winner,
   output logic       rr
);

   logic rr_q;
   logic rr_d;

   always_comb begin
      valid  = |req;
      winner = 1'b0;
      unique case (req)
         2'b01:   winner = 1'b0;
         2'b10:   winner = 1'b1;
         2'b11:   winner = rr_q;
         default: winner = 1'b0;
      endcase
      rr_d = update ? next_ptr : rr_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
      end
   end

   assign rr = rr_q;

endmodule

// File: rtl/snoop_bus_ctrl.sv
// Two-CPU snooping coherence bus controller: arbitrate, snoop the other CPU,
// then grant the winner with fill-source and invalidate qualifiers.
module snoop_bus_ctrl
   import snoop_bus_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            read_miss,
   input  logic [1:0]            write_miss,
   input  logic [1:0]            invalidate,
   input  logic [BLK_ADDR_W-1:0] BICO0,
   input  logic [BLK_ADDR_W-1:0] BICO1,
   input  logic [1:0]            cpu_search_found,
   input  logic [1:0]            block_state0,
   input  logic [1:0]            block_state1,
   output logic [1:0]            cpu_search,
   output logic [BLK_ADDR_W-1:0] BOCI0,
   output logic [BLK_ADDR_W-1:0] BOCI1,
   output logic [1:0]            grant,
   output logic [1:0]            cpu_datasel,
   output logic [1:0]            invalidate_from_other_cpu,
   output logic                  bus_err
);

   localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   sb_state_t             state_q, state_d;
   logic                  owner_q, owner_d;
   bus_op_t               op_q, op_d;
   logic [BLK_ADDR_W-1:0] addr_q, addr_d;
   logic                  found_q, found_d;
   blk_state_t            blk_q, blk_d;
   logic [TMO_W-1:0]      tmo_q, tmo_d;
   logic                  bus_err_q, bus_err_d;

   logic [1:0] req;
   logic       arb_valid;
   logic       arb_winner;
   logic       arb_rr;
   logic       grant_exit;
   logic       other;

   assign req   = read_miss | write_miss | invalidate;
   assign other = ~owner_q;

   rr_arbiter2 u_arb (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .update   (grant_exit),
      .next_ptr (other),
      .valid    (arb_valid),
      .winner   (arb_winner),
      .rr       (arb_rr)
   );

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      op_d       = op_q;
      addr_d     = addr_q;
      found_d    = found_q;
      blk_d      = blk_q;
      tmo_d      = tmo_q;
      bus_err_d  = bus_err_q;
      grant_exit = 1'b0;

      unique case (state_q)
         SB_IDLE: begin
            if (arb_valid) begin
               owner_d = arb_winner;
               addr_d  = arb_winner ? BICO1 : BICO0;
               if (write_miss[arb_winner])     op_d = OP_WR;
               else if (read_miss[arb_winner]) op_d = OP_RD;
               else                            op_d = OP_INV;
               state_d = SB_SNOOP;
            end
         end
         SB_SNOOP: state_d = SB_RESP;
         SB_RESP: begin
            found_d = cpu_search_found[other];
            blk_d   = blk_state_t'(other ? block_state1 : block_state0);
            tmo_d   = '0;
            state_d = SB_GRANT;
         end
         SB_GRANT: begin
            // A released request ends the grant cleanly even on the last allowed cycle.
            if (!req[owner_q]) begin
               grant_exit = 1'b1;
               state_d    = SB_IDLE;
            end else if (tmo_q == TMO_LAST) begin
               grant_exit = 1'b1;
               bus_err_d  = 1'b1;
               state_d    = SB_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: state_d = SB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= SB_IDLE;
         owner_q   <= 1'b0;
         op_q      <= OP_RD;
         addr_q    <= '0;
         found_q   <= 1'b0;
         blk_q     <= INVALID;
         tmo_q     <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         op_q      <= op_d;
         addr_q    <= addr_d;
         found_q   <= found_d;
         blk_q     <= blk_d;
         tmo_q     <= tmo_d;
         bus_err_q <= bus_err_d;
      end
   end

   // Output decode uses only registered state and latches.
   always_comb begin
      logic busy;
      logic inv_cmd;
      logic fill_cache;

      cpu_search                = 2'b00;
      grant                     = 2'b00;
      cpu_datasel               = 2'b00;
      invalidate_from_other_cpu = 2'b00;
      BOCI0                     = '0;
      BOCI1                     = '0;

      busy       = (state_q != SB_IDLE);
      inv_cmd    = found_q && (op_q != OP_RD) && (blk_q != INVALID);
      fill_cache = found_q && (blk_q == MODIFIED) && (op_q == OP_RD || op_q == OP_WR);

      if (busy) begin
         if (other) BOCI1 = addr_q;
         else       BOCI0 = addr_q;
      end
      if (state_q == SB_SNOOP) cpu_search = cpu_onehot(other);
      if (state_q == SB_GRANT) begin
         grant = cpu_onehot(owner_q);
         if (inv_cmd)    invalidate_from_other_cpu = cpu_onehot(other);
         if (fill_cache) cpu_datasel = cpu_onehot(owner_q);
      end
   end

   assign bus_err = bus_err_q;

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Directed self-checking bench for snoop_bus_ctrl (TIMEOUT overridden to 8).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_snoop_bus_ctrl;

   logic        clk;
   logic        rst;
   logic [1:0]  read_miss, write_miss, invalidate;
   logic [10:0] BICO0, BICO1;
   logic [1:0]  cpu_search_found, block_state0, block_state1;
   logic [1:0]  cpu_search, grant, cpu_datasel, invalidate_from_other_cpu;
   logic [10:0] BOCI0, BOCI1;
   logic        bus_err;

   int compared = 0;
   int mismatched = 0;

   snoop_bus_ctrl #(.TIMEOUT(8)) dut (
      .clk                       (clk),
      .rst                       (rst),
      .read_miss                 (read_miss),
      .write_miss                (write_miss),
      .invalidate                (invalidate),
      .BICO0                     (BICO0),
      .BICO1                     (BICO1),
      .cpu_search_found          (cpu_search_found),
      .block_state0              (block_state0),
      .block_state1              (block_state1),
      .cpu_search                (cpu_search),
      .BOCI0                     (BOCI0),
      .BOCI1                     (BOCI1),
      .grant                     (grant),
      .cpu_datasel               (cpu_datasel),
      .invalidate_from_other_cpu (invalidate_from_other_cpu),
      .bus_err                   (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] rm, input logic [1:0] wm, input logic [1:0] inv,
                                input logic [10:0] a0, input logic [10:0] a1,
                                input logic [1:0] fnd, input logic [1:0] s0, input logic [1:0] s1);
      read_miss        = rm;
      write_miss       = wm;
      invalidate       = inv;
      BICO0            = a0;
      BICO1            = a1;
      cpu_search_found = fnd;
      block_state0     = s0;
      block_state1     = s1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".search"}, 32'(cpu_search), 32'h0);
      checkOutput({tag, ".grant"}, 32'(grant), 32'h0);
      checkOutput({tag, ".datasel"}, 32'(cpu_datasel), 32'h0);
      checkOutput({tag, ".inv"}, 32'(invalidate_from_other_cpu), 32'h0);
      checkOutput({tag, ".boci0"}, 32'(BOCI0), 32'h0);
      checkOutput({tag, ".boci1"}, 32'(BOCI1), 32'h0);
      checkOutput({tag, ".bus_err"}, 32'(bus_err), 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(2'b00, 2'b00, 2'b00, 11'h0, 11'h0, 2'b00, 2'b00, 2'b00);
      #1;
      checkAllZero("reset");
      tick();
      tick();
      rst = 1'b0;
      tick();

      $display("[TB] cpu0 read miss, not found");
      applyStimulus(2'b01, 2'b00, 2'b00, 11'h155, 11'h0, 2'b00, 2'b00, 2'b00);
      tick();
      checkOutput("t1.snoop.search", 32'(cpu_search), 32'h2);
      checkOutput("t1.snoop.boci1", 32'(BOCI1), 32'h155);
      checkOutput("t1.snoop.boci0", 32'(BOCI0), 32'h0);
      checkOutput("t1.snoop.grant", 32'(grant), 32'h0);
      tick();
      checkOutput("t1.resp.search", 32'(cpu_search), 32'h0);
      checkOutput("t1.resp.boci1", 32'(BOCI1), 32'h155);
      checkOutput("t1.resp.grant", 32'(grant), 32'h0);
      tick();
      checkOutput("t1.grant", 32'(grant), 32'h1);
      checkOutput("t1.datasel", 32'(cpu_datasel), 32'h0);
      checkOutput("t1.inv", 32'(invalidate_from_other_cpu), 32'h0);
      checkOutput("t1.grant.boci1", 32'(BOCI1), 32'h155);
      applyStimulus(2'b00, 2'b00, 2'b00, 11'h0, 11'h0, 2'b00, 2'b00, 2'b00);
      tick();
      checkOutput("t1.idle.grant", 32'(grant), 32'h0);
      checkOutput("t1.idle.boci1", 32'(BOCI1), 32'h0);

      $display("[TB] cpu1 read miss, cpu0 holds MODIFIED");
      applyStimulus(2'b10, 2'b00, 2'b00, 11'h0, 11'h2A7, 2'b01, 2'b10, 2'b00);
      tick();
      checkOutput("t2.snoop.search", 32'(cpu_search), 32'h1);
      checkOutput("t2.snoop.boci0", 32'(BOCI0), 32'h2A7);
      tick();
      tick();
      checkOutput("t2.grant", 32'(grant), 32'h2);
      checkOutput("t2.datasel", 32'(cpu_datasel), 32'h2);
      checkOutput("t2.inv", 32'(invalidate_from_other_cpu), 32'h0);
      applyStimulus(2'b00, 2'b00, 2'b00, 11'h0, 11'h0, 2'b00, 2'b00, 2'b00);
      tick();
      checkOutput("t2.idle.grant", 32'(grant), 32'h0);

      $display("[TB] cpu0 upgrade, cpu1 holds SHARED");
      applyStimulus(2'b00, 2'b00, 2'b01, 11'h04C, 11'h0, 2'b10, 2'b00, 2'b01);
      tick();
      tick();
      // Change the snoop inputs after RESP sampling; the qualifiers must not follow them.
      for (int i = 0; i < 3; i++) begin
         tick();
         block_state1     = 2'b00;
         cpu_search_found = 2'b00;
         checkOutput($sformatf("t3.grant[%0d]", i), 32'(grant), 32'h1);
         checkOutput($sformatf("t3.inv[%0d]", i), 32'(invalidate_from_other_cpu), 32'h2);
         checkOutput($sformatf("t3.datasel[%0d]", i), 32'(cpu_datasel), 32'h0);
      end
      applyStimulus(2'b00, 2'b00, 2'b00, 11'h0, 11'h0, 2'b00, 2'b00, 2'b00);
      tick();
      checkOutput("t3.idle.inv", 32'(invalidate_from_other_cpu), 32'h0);

      $display("[TB] simultaneous write misses after reset");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      applyStimulus(2'b00, 2'b11, 2'b00, 11'h0AA, 11'h333, 2'b00, 2'b00, 2'b00);
      tick();
      checkOutput("t4.first.search", 32'(cpu_search), 32'h2);
      checkOutput("t4.first.boci1", 32'(BOCI1), 32'h0AA);
      tick();
      tick();
      checkOutput("t4.first.grant", 32'(grant), 32'h1);
      write_miss = 2'b10;
      tick();
      checkOutput("t4.gap.grant", 32'(grant), 32'h0);
      tick();
      checkOutput("t4.second.search", 32'(cpu_search), 32'h1);
      checkOutput("t4.second.boci0", 32'(BOCI0), 32'h333);
      tick();
      tick();
      checkOutput("t4.second.grant", 32'(grant), 32'h2);
      write_miss = 2'b00;
      tick();
      // Pointer is back to cpu0: a lone cpu0 transaction moves it to cpu1.
      write_miss = 2'b01;
      tick();
      tick();
      tick();
      checkOutput("t4.solo.grant", 32'(grant), 32'h1);
      write_miss = 2'b00;
      tick();
      write_miss = 2'b11;
      tick();
      checkOutput("t4.rr1.search", 32'(cpu_search), 32'h1);
      tick();
      tick();
      checkOutput("t4.rr1.grant", 32'(grant), 32'h2);
      write_miss = 2'b00;
      tick();

      $display("[TB] cpu0 read miss held past the timeout");
      applyStimulus(2'b01, 2'b00, 2'b00, 11'h011, 11'h0, 2'b00, 2'b00, 2'b00);
      tick();
      tick();
      for (int i = 0; i < 8; i++) begin
         tick();
         checkOutput($sformatf("t5.grant[%0d]", i), 32'(grant), 32'h1);
         checkOutput($sformatf("t5.err[%0d]", i), 32'(bus_err), 32'h0);
      end
      tick();
      read_miss = 2'b00;
      checkOutput("t5.exit.grant", 32'(grant), 32'h0);
      checkOutput("t5.exit.err", 32'(bus_err), 32'h1);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput($sformatf("t5.sticky[%0d]", i), 32'(bus_err), 32'h1);
      end

      $display("[TB] reset during snoop");
      applyStimulus(2'b01, 2'b00, 2'b00, 11'h5A5, 11'h0, 2'b00, 2'b00, 2'b00);
      tick();
      checkOutput("t6.snoop.search", 32'(cpu_search), 32'h2);
      rst = 1'b1;
      #1;
      checkAllZero("t6.rst");
      applyStimulus(2'b00, 2'b00, 2'b00, 11'h0, 11'h0, 2'b00, 2'b00, 2'b00);
      tick();
      rst = 1'b0;
      tick();
      checkAllZero("t6.post");
      applyStimulus(2'b10, 2'b00, 2'b00, 11'h0, 11'h7FF, 2'b00, 2'b00, 2'b00);
      tick();
      checkOutput("t6.new.search", 32'(cpu_search), 32'h1);
      checkOutput("t6.new.boci0", 32'(BOCI0), 32'h7FF);
      tick();
      checkOutput("t6.new.early", 32'(grant), 32'h0);
      tick();
      checkOutput("t6.new.grant", 32'(grant), 32'h2);
      applyStimulus(2'b00, 2'b00, 2'b00, 11'h0, 11'h0, 2'b00, 2'b00, 2'b00);
      tick();
      checkOutput("t6.new.idle", 32'(grant), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
